// File: rtl/rx_string_pkg.sv
// Shared constants, state encodings and byte compare for the UART string checker.
// Build option RX_STRING_CASE_INSENSITIVE_EN folds ASCII letter case when comparing.
package rx_string_pkg;

    localparam logic [7:0]  ASCII_H = 8'h48;
    localparam logic [15:0] MIN_DIV = 16'd4;

    // "Hello1234567890\r", index 0 first
    localparam logic [0:15][7:0] EXP_STRING = {
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h31, 8'h32, 8'h33,
        8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30, 8'h0D
    };

    typedef enum logic [1:0] {ChkIdle, ChkHunt, ChkMatch} chk_state_e;

    typedef enum logic [2:0] {DsIdle, DsStart, DsData, DsStop, DsWaitHigh} ds_state_e;

`ifdef RX_STRING_CASE_INSENSITIVE_EN
    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction
`endif

    function automatic logic byte_match(input logic [7:0] rx, input logic [7:0] expd);
`ifdef RX_STRING_CASE_INSENSITIVE_EN
        if (is_letter(rx) && is_letter(expd)) begin
            return (rx | 8'h20) == (expd | 8'h20);
        end
`endif
        return rx == expd;
    endfunction

endpackage

// File: rtl/rx_string_deser.sv
// 2-FF synchroniser, 8N1 deserialiser and free-running bit-time tick.
module rx_string_deser
    import rx_string_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_div,
    input  logic        i_u_rx,
    output logic        o_byte_valid,
    output logic [7:0]  o_byte,
    output logic        o_frame_err,
    output logic        o_bit_tick
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    ds_state_e   r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_tick_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [15:0] w_div;

    assign w_div = (i_div < MIN_DIV) ? MIN_DIV : i_div;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_u_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // >= keeps the tick sane if i_div shrinks while the counter is high
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            o_bit_tick <= 1'b0;
        end else if (r_tick_cnt >= w_div - 16'd1) begin
            r_tick_cnt <= '0;
            o_bit_tick <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
            o_bit_tick <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= DsIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                DsIdle: begin
                    if (!r_sync2 && r_prev) begin
                        r_cnt   <= {1'b0, w_div[15:1]} - 16'd1;
                        r_state <= DsStart;
                    end
                end
                DsStart: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else if (r_sync2) begin
                        r_state <= DsIdle;
                    end else begin
                        r_cnt     <= w_div - 16'd1;
                        r_bit_idx <= '0;
                        r_state   <= DsData;
                    end
                end
                DsData: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= w_div - 16'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= DsStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                DsStop: begin
                    if (r_cnt != 16'd0) begin
                        r_cnt <= r_cnt - 16'd1;
                    end else begin
                        if (r_sync2) begin
                            o_byte_valid <= 1'b1;
                            o_byte       <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        r_state <= DsWaitHigh;
                    end
                end
                DsWaitHigh: begin
                    if (r_sync2) begin
                        r_state <= DsIdle;
                    end
                end
                default: r_state <= DsIdle;
            endcase
        end
    end

endmodule

// File: rtl/rx_string_check.sv
// Checks received bytes against the fixed test string; strobes pass/fail and keeps counters.
// Define RX_STRING_CASE_INSENSITIVE_EN to compare ASCII letters without regard to case.
module rx_string_check #(
    parameter int unsigned STR_LEN      = 16,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_div,
    input  logic        i_u_rx,
    output logic        o_busy,
    output logic        o_pass,
    output logic        o_fail,
    output logic [3:0]  o_err_index,
    output logic [15:0] o_pass_cnt,
    output logic [15:0] o_fail_cnt
);
    import rx_string_pkg::*;

    localparam int unsigned TW = $clog2(TIMEOUT_BITS + 1);

    logic          w_byte_valid;
    logic [7:0]    w_byte;
    logic          w_frame_err;
    logic          w_bit_tick;
    logic          w_timeout;
    logic          w_last;
    logic [7:0]    w_exp;

    chk_state_e    r_state;
    logic [3:0]    r_idx;
    logic [TW-1:0] r_to_cnt;
    logic          r_pass;
    logic          r_fail;
    logic [3:0]    r_err_index;
    logic [15:0]   r_pass_cnt;
    logic [15:0]   r_fail_cnt;

    rx_string_deser u_deser (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_div        (i_div),
        .i_u_rx       (i_u_rx),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err),
        .o_bit_tick   (w_bit_tick)
    );

    assign w_exp     = EXP_STRING[r_idx];
    assign w_last    = (r_idx == 4'(STR_LEN - 1));
    assign w_timeout = (r_to_cnt >= TW'(TIMEOUT_BITS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ChkIdle;
            r_idx       <= '0;
            r_to_cnt    <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_err_index <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                ChkIdle: begin
                    if (i_en) r_state <= ChkHunt;
                end
                ChkHunt: begin
                    if (!i_en) begin
                        r_state <= ChkIdle;
                    end else if (w_byte_valid && byte_match(w_byte, ASCII_H)) begin
                        r_idx    <= 4'd1;
                        r_to_cnt <= '0;
                        r_state  <= ChkMatch;
                    end
                end
                ChkMatch: begin
                    // A byte landing with the timeout takes priority over it
                    if (w_byte_valid) begin
                        r_to_cnt <= '0;
                        if (byte_match(w_byte, w_exp)) begin
                            if (w_last) begin
                                r_pass     <= 1'b1;
                                r_pass_cnt <= (r_pass_cnt == 16'hFFFF) ? r_pass_cnt
                                                                       : r_pass_cnt + 16'd1;
                                r_state    <= i_en ? ChkHunt : ChkIdle;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end else begin
                            r_fail      <= 1'b1;
                            r_err_index <= r_idx;
                            r_fail_cnt  <= (r_fail_cnt == 16'hFFFF) ? r_fail_cnt
                                                                    : r_fail_cnt + 16'd1;
                            if (byte_match(w_byte, ASCII_H)) begin
                                r_idx <= 4'd1;
                            end else begin
                                r_state <= i_en ? ChkHunt : ChkIdle;
                            end
                        end
                    end else if (w_frame_err || w_timeout) begin
                        r_fail      <= 1'b1;
                        r_err_index <= r_idx;
                        r_fail_cnt  <= (r_fail_cnt == 16'hFFFF) ? r_fail_cnt
                                                                : r_fail_cnt + 16'd1;
                        r_to_cnt    <= '0;
                        r_state     <= i_en ? ChkHunt : ChkIdle;
                    end else if (w_bit_tick) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= ChkIdle;
            endcase
        end
    end

    assign o_busy      = (r_state != ChkIdle);
    assign o_pass      = r_pass;
    assign o_fail      = r_fail;
    assign o_err_index = r_err_index;
    assign o_pass_cnt  = r_pass_cnt;
    assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_rx_string_check.sv
// Directed bench for rx_string_check with a string-level reference model and strobe scoreboard.
module tb_rx_string_check;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [15:0] div = 16'd16;
    logic        rx = 1'b1;
    logic        o_busy, o_pass, o_fail;
    logic [3:0]  o_err_index;
    logic [15:0] o_pass_cnt, o_fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int bit_clks = 16;

    string good_s = "Hello1234567890\r";

    // model state: m_idx==0 means hunting
    int m_idx = 0;
    bit m_en = 1'b1;
    int m_pass_cnt = 0;
    int m_fail_cnt = 0;
    int m_err_idx = 0;
    bit q_is_pass[$];
    int q_idx[$];

    always #5 clk = ~clk;

    rx_string_check dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_div       (div),
        .i_u_rx      (rx),
        .o_busy      (o_busy),
        .o_pass      (o_pass),
        .o_fail      (o_fail),
        .o_err_index (o_err_index),
        .o_pass_cnt  (o_pass_cnt),
        .o_fail_cnt  (o_fail_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit m_eq(input byte unsigned a, input byte unsigned e);
`ifdef RX_STRING_CASE_INSENSITIVE_EN
        if (a >= "A" && a <= "Z") a = a + 8'd32;
        if (e >= "A" && e <= "Z") e = e + 8'd32;
`endif
        return a == e;
    endfunction

    task automatic m_fail_evt();
        if (m_fail_cnt < 65535) m_fail_cnt++;
        m_err_idx = m_idx;
        q_is_pass.push_back(1'b0);
        q_idx.push_back(m_idx);
    endtask

    task automatic model_byte(input byte unsigned b, input bit frame_ok);
        if (m_idx == 0) begin
            if (m_en && frame_ok && m_eq(b, "H")) m_idx = 1;
        end else if (!frame_ok) begin
            m_fail_evt();
            m_idx = 0;
        end else if (m_eq(b, good_s[m_idx])) begin
            if (m_idx == good_s.len() - 1) begin
                if (m_pass_cnt < 65535) m_pass_cnt++;
                q_is_pass.push_back(1'b1);
                q_idx.push_back(0);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end else begin
            m_fail_evt();
            m_idx = m_eq(b, "H") ? 1 : 0;
        end
    endtask

    task automatic model_timeout();
        if (m_idx != 0) begin
            m_fail_evt();
            m_idx = 0;
        end
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_pass_cnt = 0;
        m_fail_cnt = 0;
        m_err_idx = 0;
        q_is_pass.delete();
        q_idx.delete();
    endtask

    // Scoreboard: every strobe must match the next expected event; reset forces all zero
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset outputs", {o_busy, o_pass, o_fail, o_err_index, o_pass_cnt, o_fail_cnt},
                  64'd0);
        end else if (o_pass || o_fail) begin
            if (q_is_pass.size() == 0) begin
                check("unexpected strobe", {o_pass, o_fail}, 2'b00);
            end else begin
                bit exp_pass;
                int exp_idx;
                exp_pass = q_is_pass.pop_front();
                exp_idx  = q_idx.pop_front();
                check("strobe kind", {o_pass, o_fail}, exp_pass ? 2'b10 : 2'b01);
                if (!exp_pass) check("strobe err_index", o_err_index, exp_idx);
            end
        end
    end

    task automatic bit_time(input logic v);
        rx = v;
        repeat (bit_clks) @(posedge clk);
    endtask

    task automatic send_byte(input byte unsigned b, input bit stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        model_byte(b, stop);
        bit_time(stop);
        if (!stop) bit_time(1'b1);
        bit_time(1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        rx = 1'b1;
        model_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic checkpoint(input string name);
        repeat (3 * bit_clks) @(posedge clk);
        check({name, " pending"}, q_is_pass.size(), 0);
        check({name, " pass_cnt"}, o_pass_cnt, m_pass_cnt);
        check({name, " fail_cnt"}, o_fail_cnt, m_fail_cnt);
        check({name, " err_index"}, o_err_index, m_err_idx);
        check({name, " busy"}, o_busy, (m_en || m_idx != 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int glitch_bytes;
        repeat (4) @(posedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("busy after enable", o_busy, 1'b1);

        send_str(good_s);
        checkpoint("good");
        check("good pass_cnt literal", o_pass_cnt, 16'd1);
        check("good fail_cnt literal", o_fail_cnt, 16'd0);

        do_reset();
        send_str("Hello12X4567890\r");
        checkpoint("mismatch");
        check("mismatch err literal", o_err_index, 4'd7);
        check("mismatch fail literal", o_fail_cnt, 16'd1);

        do_reset();
        send_str("Hel");
        model_timeout();
        repeat (50) bit_time(1'b1);
        checkpoint("timeout");
        check("timeout err literal", o_err_index, 4'd3);
        send_str(good_s);
        checkpoint("after timeout");
        check("after timeout pass literal", o_pass_cnt, 16'd1);

        do_reset();
        send_str("Hello");
        send_byte(8'h31, 1'b0);
        checkpoint("frame");
        check("frame err literal", o_err_index, 4'd5);

        glitch_bytes = 0;
        rx = 1'b0;
        repeat (bit_clks / 4) @(posedge clk);
        rx = 1'b1;
        repeat (12 * bit_clks) begin
            @(negedge clk);
            if (dut.w_byte_valid || dut.w_frame_err) glitch_bytes++;
        end
        check("glitch no byte", glitch_bytes, 0);
        checkpoint("glitch");

        do_reset();
        send_str("Hello12345");
        en = 1'b0;
        m_en = 1'b0;
        send_str("67890\r");
        checkpoint("en drop");
        check("en drop busy literal", o_busy, 1'b0);
        send_str(good_s);
        checkpoint("disabled");
        en = 1'b1;
        m_en = 1'b1;

        repeat (2) @(posedge clk);
        send_str("Hello");
        rx = 1'b0;
        repeat (3 * bit_clks) @(posedge clk);
        do_reset();
        send_str(good_s);
        checkpoint("post reset");
        check("post reset pass literal", o_pass_cnt, 16'd1);

        do_reset();
        force dut.r_pass_cnt = 16'hFFFF;
        @(posedge clk);
        release dut.r_pass_cnt;
        m_pass_cnt = 65535;
        send_str(good_s);
        checkpoint("saturate");
        check("saturate literal", o_pass_cnt, 16'hFFFF);

        do_reset();
        send_str("HELLO1234567890\r");
        checkpoint("case");
`ifdef RX_STRING_CASE_INSENSITIVE_EN
        check("case pass literal", o_pass_cnt, 16'd1);
`else
        check("case err literal", o_err_index, 4'd1);
        check("case fail literal", o_fail_cnt, 16'd1);
`endif

        div = 16'd2;
        bit_clks = 4;
        do_reset();
        send_str(good_s);
        checkpoint("min div");
        check("min div pass literal", o_pass_cnt, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_string_check.md
Name: rx_string_check

Overview:
- Receive-side checker for the fixed UART test string "Hello1234567890\r" (0x48 65 6C 6C 6F 31 32 33 34 35 36 37 38 39 30 0D), 8N1, baud = clk/i_div.
- Deserialises the RX line, hunts for the first byte, then compares each byte in sequence.
- Reports a pass or fail per string and keeps saturating counters. Sits on the board RX pin for loopback or board-to-board link tests.

Parameters:
- STR_LEN, 16, number of bytes in the expected string (4-bit index covers 16).
- TIMEOUT_BITS, 40, allowed idle bit-times between bytes inside a string before a fail.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous reset, active-low
- i_en  in  1  enable checking; 0 parks the checker in IDLE after any string in progress
- i_div  in  16  clocks per bit; values below 4 are treated as 4
- i_u_rx  in  1  UART line, idle high, asynchronous to i_clk
- o_busy  out  1  high whenever the FSM is not IDLE
- o_pass  out  1  one-cycle strobe when a full string has matched
- o_fail  out  1  one-cycle strobe on mismatch, framing error, or timeout within a string
- o_err_index  out  4  byte index of the last failure; held until the next failure
- o_pass_cnt  out  16  number of passed strings, saturates at 0xFFFF
- o_fail_cnt  out  16  number of failed strings, saturates at 0xFFFF

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - The synchroniser chain resets to 1.
- Input path: 2-FF synchroniser on i_u_rx. Total latency from the stop-bit sample to byte_valid is 1 cycle.
- Deserialiser:
  - IDLE→START on a falling edge of the synchronised line.
  - Wait div/2 cycles, resample. If the line is high, treat it as a glitch and return to idle with no byte.
  - Sample 8 data bits (LSB first), one every div cycles.
  - Sample the stop bit div cycles later.
  - Stop bit = 1: emit byte_valid with the byte.
  - Stop bit = 0: emit frame_err and no byte.
  - Then wait for the line to go high before accepting the next start bit.
- Checker FSM states: IDLE, HUNT, MATCH.
  - IDLE: when i_en=1, go to HUNT on the next cycle.
  - HUNT, i_en=0: go to IDLE.
  - HUNT, byte 0x48: idx=1, go to MATCH.
  - HUNT, any other byte or a frame_err: discarded silently, no fail.
  - MATCH, byte == EXP[idx]:
    - If idx==STR_LEN-1: pulse o_pass, pass_cnt+1 (saturating), go to HUNT (or IDLE if i_en=0).
    - Otherwise idx+1.
  - MATCH, mismatch:
    - Pulse o_fail, o_err_index=idx, fail_cnt+1 (saturating).
    - If the byte is 0x48: resync with idx=1 and stay in MATCH.
    - Otherwise go to HUNT.
  - MATCH, frame_err: fail with o_err_index=idx, go to HUNT.
  - MATCH, timeout: a bit-time tick counter reaches TIMEOUT_BITS with no byte_valid → fail with o_err_index=idx, go to HUNT. The counter clears on every byte_valid and on entry to MATCH.
- i_en falling during MATCH: the string completes (pass, fail or timeout) before the FSM drops to IDLE.
- A byte and a timeout in the same cycle: the byte wins.
- Strobe timing: o_pass and o_fail assert 1 cycle after byte_valid. They are never both high in the same cycle.
- Reset asserted mid-byte or mid-string: everything returns to reset values immediately, with no strobes.

Optional Feature:
- Macro: RX_STRING_CASE_INSENSITIVE_EN.
- Defined: letters 0x41-0x5A and 0x61-0x7A are compared with bit 5 masked. This applies to the HUNT detection of 'H'/'h' as well. "HELLO1234567890\r" passes.
- Undefined: exact byte compare. "HELLO…" fails at idx 1.

Decomposition:
- Package/include rx_string_pkg:
  - EXP_STRING constant (16×8)
  - ASCII_H=8'h48
  - checker state encoding
  - deserialiser state encoding
  - MIN_DIV=4
- Sub-module rx_string_deser contains:
  - the synchroniser
  - the 8N1 deserialiser
  - the bit-time tick
  - outputs: byte_valid, byte, frame_err, bit_tick
- rx_string_check holds the checker FSM and the counters.

Test Plan:
- i_div=16, i_en=1, send the exact 16-byte string → one o_pass after the 0x0D stop bit; pass_cnt=1, fail_cnt=0, o_err_index=0.
- Send "Hello12X4567890\r" (byte 7 = 0x58) → o_fail at byte 7, o_err_index=7, fail_cnt=1. The trailing bytes are discarded in HUNT, with no second fail.
- Send "Hel", then idle for 50 bit-times → o_fail with o_err_index=3 after 40 bit-times; a following full string passes (pass_cnt=1).
- Send 0x31 with a stop bit of 0 mid-string (idx 5) → o_fail with o_err_index=5. A 1-bit-time/4 start-bit glitch while in HUNT → no byte and no strobe.
- Drop i_en at idx 10 and finish the string → o_pass, then o_busy=0. Assert i_rst_n=0 mid-byte → all outputs 0, and a subsequent full string passes.
- Force pass_cnt to 0xFFFF and send one more good string → the counter stays at 0xFFFF. With RX_STRING_CASE_INSENSITIVE_EN, "hELLO1234567890\r" → o_pass.
